caesar3_decipher_pipe: RTL and testbench
========================================

Name: caesar3_decipher_pipe

Overview:
Streaming 3-stage Caesar decipher. It is the receive-side counterpart of the team's combinational 3-stage Caesar encryptor.
- Ciphertext letters enter on a valid/ready interface and pass through three registered un-shift stages in the order K3, K2, K1.
- Recovered plaintext leaves on a valid/ready interface.
- Keys load through a req/ack handshake that only completes when the pipeline is empty.

Parameters:
CNT_W, 16, width of the saturating error-character counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
key_load  in  1  request to load new keys; hold high until key_ack
k1_dir  in  1  stage-1 shift direction (0 = right, 1 = left, encryption sense)
k1_num  in  5  stage-1 shift amount
k3_dir  in  1  stage-3 shift direction
k3_num  in  5  stage-3 shift amount
key_ack  out  1  one-cycle pulse: keys captured
err_key  out  1  captured keys invalid
in_valid  in  1  ciphertext char valid
in_ready  out  1  block accepts char
in_char  in  8  ASCII ciphertext char
out_valid  out  1  plaintext char valid
out_ready  in  1  sink accepts char
out_char  out  8  ASCII plaintext char (0x00 if input was not a letter)
out_err_char  out  1  qualifies out_char: input was not a letter
err_count  out  CNT_W  saturating count of non-letter chars delivered

Behaviour:
Reset (async, rst=1):
- Key registers = 0; key_valid = 0, so err_key = 1.
- All stage valids = 0; out_valid = 0, out_char = 0x00, out_err_char = 0.
- key_ack = 0, err_count = 0.

Key handshake:
- Capture occurs when key_load = 1 and all three stage valids = 0.
- On capture, k1/k3 dir/num are registered and key_ack pulses for 1 cycle on the next cycle.
- While the pipeline is non-empty, key_load is ignored (no ack) and the old keys stay in force.
- key_valid = (k1_num <= 26) && (k3_num <= 26) && (k1_num != k3_num), computed on the captured values.
- err_key = !key_valid, registered.
- Derived keys, from registered values: K2 = (K1 + K3) mod 27 using a 6-bit sum (subtract 27 if sum >= 27); D2 = D1 ^ D3.

Input handshake:
- adv = !s3_valid || out_ready.
- in_ready = adv && key_valid && !key_load.
- A transfer occurs when in_valid && in_ready.

Pipeline:
- Three registers S1, S2, S3, each holding {valid, char, is_upper, is_letter}.
- All stages advance together when adv = 1 and hold when adv = 0 (global stall).
- A bubble enters S1 when there is no transfer.
- Latency: 3 cycles from accept to out_valid with no stall. Throughput: 1 char/cycle.
- Stage order: S1 undoes (D3, K3), S2 undoes (D2, K2), S3 undoes (D1, K1).

Stage arithmetic:
- idx = char - base, where base = 0x41 for uppercase and 0x61 for lowercase; idx is 0..25.
- s = K mod 26 (K = 26 gives s = 0).
- D = 0 (encryptor shifted right): idx' = (idx - s) mod 26.
- D = 1: idx' = (idx + s) mod 26.
- Wrap is done by a single conditional ±26 on a 6-bit intermediate.
- Case is preserved.
- Non-letter: classified at S1. char is forced to 0x00, is_letter = 0, and stages pass it unchanged.

Output:
- out_valid = s3_valid; out_char = S3 char; out_err_char = !S3 is_letter.
- Outputs are stable while out_valid && !out_ready.
- err_count increments on each output transfer with out_err_char = 1 and saturates at all-ones.

Boundary conditions:
- Simultaneous key_load and in_valid: key_load has priority because in_ready = 0.
- Key change affects only chars accepted after key_ack.
- Reset mid-stream discards all in-flight chars.

Test Plan:
1. Basic un-shift. Load K1 = 3 (D1 = 0), K3 = 5 (D3 = 0). Send 'Q' (0x51) with out_ready = 1 -> key_ack pulse, err_key = 0, out_char = 'A' (0x41) exactly 3 cycles after accept.
2. Mixed directions. Load K1 = 20 (D1 = 1), K3 = 10 (D3 = 0), giving K2 = 3, D2 = 1. Send 'n' -> 'a'. Send 'N' -> 'A'.
3. Wrap with the 26 key. Load K1 = 26 (D1 = 0), K3 = 25 (D3 = 1), giving K2 = 24. Send 'c' -> 'z'. Send 'C' -> 'Z'.
4. Invalid keys. Load K1 = K3 = 7 -> key_ack pulses, err_key = 1, in_ready = 0. Reload K1 = 27, K3 = 1 -> err_key = 1. Reload K1 = 1, K3 = 2 -> err_key = 0, in_ready = 1.
5. Backpressure and key_load blocked.
   - Stream "ABCDE" with out_ready = 0 -> exactly 3 accepted, in_ready = 0, out_char held at the first decrypted char.
   - Assert key_load during the stall -> no key_ack.
   - Release out_ready -> all 5 delivered in order; key_ack follows once the pipeline drains.
6. Non-letters and reset. Send '5', '@', 'z' -> outputs 0x00/err, 0x00/err, decrypted 'z'/no err; err_count = 2. Assert rst mid-stream -> out_valid = 0, err_count = 0, err_key = 1 immediately.

Source files
------------

// File: rtl/caesar3_decipher_pipe.sv
// Streaming 3-stage Caesar decipher: un-shifts K3, K2, K1 in three registered stages, 3-cycle latency, 1 char/cycle.
// Global stall: all stages hold while S3 is full and the sink is not ready; keys load only when the pipe is empty.
module caesar3_decipher_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_load,
    input  logic             k1_dir,
    input  logic [4:0]       k1_num,
    input  logic             k3_dir,
    input  logic [4:0]       k3_num,
    output logic             key_ack,
    output logic             err_key,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_char,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_char,
    output logic             out_err_char,
    output logic [CNT_W-1:0] err_count
);

    typedef struct packed {
        logic       vld;
        logic [7:0] ch;
        logic       upper;
        logic       letter;
    } stage_t;

    localparam stage_t STAGE_RST = '{vld: 1'b0, ch: 8'h00, upper: 1'b0, letter: 1'b1};

    // Undo one encryptor stage; non-letters pass through untouched.
    function automatic stage_t unshift(input stage_t s, input logic dir, input logic [5:0] key);
        stage_t     r;
        logic [7:0] base;
        logic [7:0] diff;
        logic [5:0] idx;
        logic [5:0] amt;
        logic [5:0] t;
        r    = s;
        base = s.upper ? 8'h41 : 8'h61;
        diff = s.ch - base;
        idx  = diff[5:0];
        amt  = (key >= 6'd26) ? key - 6'd26 : key;
        if (!dir) begin
            t = idx - amt;
            if (idx < amt) t = t + 6'd26;
        end else begin
            t = idx + amt;
            if (t >= 6'd26) t = t - 6'd26;
        end
        if (s.letter) r.ch = base + {2'b00, t};
        return r;
    endfunction

    logic       k1_dir_q, k3_dir_q;
    logic [4:0] k1_num_q, k3_num_q;
    logic       key_valid;

    stage_t s1, s2, s3;
    stage_t in_stage;

    logic [5:0] k_sum;
    logic [5:0] k2;
    logic       d2;
    logic       adv;
    logic       xfer;
    logic       pipe_empty;
    logic       capture;
    logic       new_key_valid;
    logic       is_up;
    logic       is_lo;

    assign k_sum = {1'b0, k1_num_q} + {1'b0, k3_num_q};
    assign k2    = (k_sum >= 6'd27) ? k_sum - 6'd27 : k_sum;
    assign d2    = k1_dir_q ^ k3_dir_q;

    assign adv        = !s3.vld || out_ready;
    assign in_ready   = adv && key_valid && !key_load;
    assign xfer       = in_valid && in_ready;
    assign pipe_empty = !s1.vld && !s2.vld && !s3.vld;
    assign capture    = key_load && pipe_empty;

    assign new_key_valid = (k1_num <= 5'd26) && (k3_num <= 5'd26) && (k1_num != k3_num);

    assign is_up = (in_char >= 8'h41) && (in_char <= 8'h5A);
    assign is_lo = (in_char >= 8'h61) && (in_char <= 8'h7A);

    always_comb begin
        in_stage        = STAGE_RST;
        in_stage.vld    = xfer;
        in_stage.upper  = is_up;
        in_stage.letter = is_up || is_lo;
        in_stage.ch     = (is_up || is_lo) ? in_char : 8'h00;
    end

    assign out_valid    = s3.vld;
    assign out_char     = s3.ch;
    assign out_err_char = !s3.letter;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k1_dir_q  <= 1'b0;
            k1_num_q  <= 5'd0;
            k3_dir_q  <= 1'b0;
            k3_num_q  <= 5'd0;
            key_valid <= 1'b0;
            err_key   <= 1'b1;
            key_ack   <= 1'b0;
            s1        <= STAGE_RST;
            s2        <= STAGE_RST;
            s3        <= STAGE_RST;
            err_count <= '0;
        end else begin
            key_ack <= capture;
            if (capture) begin
                k1_dir_q  <= k1_dir;
                k1_num_q  <= k1_num;
                k3_dir_q  <= k3_dir;
                k3_num_q  <= k3_num;
                key_valid <= new_key_valid;
                err_key   <= !new_key_valid;
            end
            if (adv) begin
                s1 <= unshift(in_stage, k3_dir_q, {1'b0, k3_num_q});
                s2 <= unshift(s1, d2, k2);
                s3 <= unshift(s2, k1_dir_q, {1'b0, k1_num_q});
            end
            if (out_valid && out_ready && out_err_char && (err_count != {CNT_W{1'b1}}))
                err_count <= err_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_caesar3_decipher_pipe.sv
// Bench for caesar3_decipher_pipe: directed vector table, hand-written stall/reset sequences, random stream vs reference model.
module tb_caesar3_decipher_pipe;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          key_load;
    logic          k1_dir;
    logic [4:0]    k1_num;
    logic          k3_dir;
    logic [4:0]    k3_num;
    logic          key_ack;
    logic          err_key;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_char;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_char;
    logic          out_err_char;
    logic [CW-1:0] err_count;

    caesar3_decipher_pipe #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .key_load(key_load), .k1_dir(k1_dir), .k1_num(k1_num), .k3_dir(k3_dir), .k3_num(k3_num),
        .key_ack(key_ack), .err_key(err_key),
        .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
        .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char),
        .out_err_char(out_err_char), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    bit cur_d1, cur_d3;
    int cur_n1, cur_n3;

    typedef struct {
        bit d1;
        int n1;
        bit d3;
        int n3;
        int ch;
        int exp;   // {err, char} packed as err*256 + char
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int amt(input bit d, input int k);
        return d ? (k % 26) : -(k % 26);
    endfunction

    // Net effect of the three un-shifts, applied as one modular rotation.
    function automatic int ref_dec(input int c, input bit d1, input int n1, input bit d3, input int n3);
        int k2;
        int a;
        k2 = (n1 + n3) % 27;
        a  = amt(d3, n3) + amt(d1 ^ d3, k2) + amt(d1, n1);
        if (c >= 65 && c <= 90)  return 65 + (c - 65 + a + 104) % 26;
        if (c >= 97 && c <= 122) return 97 + (c - 97 + a + 104) % 26;
        return 256;
    endfunction

    function automatic int rand_char();
        int r;
        r = $urandom % 3;
        if (r == 0) return 65 + $urandom % 26;
        if (r == 1) return 97 + $urandom % 26;
        return $urandom % 256;
    endfunction

    function automatic int got_word();
        return (out_err_char ? 256 : 0) + int'(out_char);
    endfunction

    task automatic load_keys(input bit d1, input int n1, input bit d3, input int n3);
        int t;
        key_load = 1'b1;
        k1_dir = d1; k1_num = 5'(n1);
        k3_dir = d3; k3_num = 5'(n3);
        t = 0;
        do begin
            tick();
            t++;
        end while (!key_ack && t < 50);
        key_load = 1'b0;
        check("key_ack_seen", int'(key_ack), 1);
        cur_d1 = d1; cur_n1 = n1; cur_d3 = d3; cur_n3 = n3;
        #1;
    endtask

    task automatic send_char(input int c, input int exp, input string name);
        int t;
        int lat;
        in_valid = 1'b1; in_char = 8'(c); out_ready = 1'b1;
        #1;
        t = 0;
        while (!in_ready && t < 20) begin
            tick();
            t++;
        end
        check({name, "_accept"}, int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({name, "_latency"}, lat, 3);
        check(name, got_word(), exp);
        tick();
    endtask

    task automatic run_random(input int cycles, inout int q[$], inout int cnt);
        int e;
        for (int c = 0; c < cycles + 10; c++) begin
            in_valid  = (c < cycles) && ($urandom % 10 < 7);
            in_char   = 8'(rand_char());
            out_ready = (c >= cycles) || ($urandom % 10 < 7);
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("rand_spurious_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("rand_out", got_word(), e);
                    if (e >= 256 && cnt < (1 << CW) - 1) cnt++;
                end
            end
            if (in_valid && in_ready) q.push_back(ref_dec(int'(in_char), cur_d1, cur_n1, cur_d3, cur_n3));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("rand_drained", q.size(), 0);
        check("rand_err_count", int'(err_count), cnt);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        byte unsigned abc[5];
        int acc, got, acks, ack_got, cnt, n1, n3;
        int q[$];
        bit ack_seen;
        int held;

        vecs = '{
            '{0, 3, 0, 5, 'h51, 'h41},
            '{1, 20, 0, 10, 'h6E, 'h61},
            '{1, 20, 0, 10, 'h4E, 'h41},
            '{0, 26, 1, 25, 'h63, 'h7A},
            '{0, 26, 1, 25, 'h43, 'h5A},
            '{0, 3, 0, 5, 'h35, 'h100},
            '{0, 3, 0, 5, 'h40, 'h100},
            '{0, 3, 0, 5, 'h7A, 'h6A}
        };
        abc = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};

        rst = 1'b1; key_load = 1'b0; k1_dir = 1'b0; k1_num = 5'd0; k3_dir = 1'b0; k3_num = 5'd0;
        in_valid = 1'b0; in_char = 8'h41; out_ready = 1'b1;
        tick(); tick();
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_char", int'(out_char), 0);
        check("rst_out_err_char", int'(out_err_char), 0);
        check("rst_key_ack", int'(key_ack), 0);
        check("rst_err_key", int'(err_key), 1);
        check("rst_err_count", int'(err_count), 0);
        check("rst_in_ready", int'(in_ready), 0);
        rst = 1'b0;
        tick();

        // Directed vectors, including non-letters
        foreach (vecs[i]) begin
            load_keys(vecs[i].d1, vecs[i].n1, vecs[i].d3, vecs[i].n3);
            check($sformatf("vec%0d_err_key", i), int'(err_key), 0);
            send_char(vecs[i].ch, vecs[i].exp, $sformatf("vec%0d_char", i));
        end
        check("err_count_after_table", int'(err_count), 2);

        // Invalid keys
        load_keys(0, 7, 0, 7);
        check("equal_keys_err_key", int'(err_key), 1);
        check("equal_keys_in_ready", int'(in_ready), 0);
        tick();
        check("key_ack_one_cycle", int'(key_ack), 0);
        load_keys(0, 27, 0, 1);
        check("k27_err_key", int'(err_key), 1);
        load_keys(0, 1, 0, 2);
        check("good_keys_err_key", int'(err_key), 0);
        check("good_keys_in_ready", int'(in_ready), 1);

        // Backpressure: only three chars fit, output held, key_load blocked
        out_ready = 1'b0; in_valid = 1'b1; in_char = abc[0]; acc = 0;
        #1;
        for (int i = 0; i < 8; i++) begin
            if (in_ready && acc < 5) begin
                @(posedge clk);
                #1;
                acc++;
                in_char = abc[acc < 5 ? acc : 4];
            end else begin
                tick();
            end
        end
        check("stall_accepted", acc, 3);
        check("stall_in_ready", int'(in_ready), 0);
        check("stall_out_valid", int'(out_valid), 1);
        held = ref_dec(int'(abc[0]), cur_d1, cur_n1, cur_d3, cur_n3);
        check("stall_out_char", got_word(), held);
        key_load = 1'b1; k1_dir = 1'b0; k1_num = 5'd9; k3_dir = 1'b0; k3_num = 5'd4;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            acks += int'(key_ack);
            check("stall_out_held", got_word(), held);
        end
        check("stall_no_key_ack", acks, 0);
        key_load = 1'b0;

        out_ready = 1'b1; got = 0; ack_seen = 1'b0; ack_got = -1;
        #1;
        for (int i = 0; i < 40 && !(got == 5 && ack_seen); i++) begin
            bit xf;
            xf = in_valid && in_ready;
            if (out_valid) begin
                check($sformatf("drain_out%0d", got), got_word(),
                      ref_dec(int'(abc[got < 5 ? got : 4]), cur_d1, cur_n1, cur_d3, cur_n3));
                got++;
            end
            @(posedge clk);
            #1;
            if (key_ack && !ack_seen) begin
                ack_seen = 1'b1;
                ack_got = got;
                check("ack_pipe_empty", int'(out_valid), 0);
                key_load = 1'b0;
            end
            if (xf) begin
                acc++;
                if (acc < 5) begin
                    in_char = abc[acc];
                end else begin
                    in_valid = 1'b0;
                    key_load = 1'b1;
                end
            end
        end
        check("drain_count", got, 5);
        check("ack_after_drain", ack_got, 5);
        cur_d1 = 1'b0; cur_n1 = 9; cur_d3 = 1'b0; cur_n3 = 4;
        check("new_keys_err_key", int'(err_key), 0);

        // Simultaneous key_load and in_valid: the load wins
        in_valid = 1'b1; in_char = 8'h58;
        key_load = 1'b1; k1_dir = 1'b1; k1_num = 5'd2; k3_dir = 1'b0; k3_num = 5'd6;
        #1;
        check("load_prio_in_ready", int'(in_ready), 0);
        load_keys(1, 2, 0, 6);
        in_valid = 1'b0;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            acks += int'(out_valid);
        end
        check("load_prio_no_char", acks, 0);
        send_char('h6B, ref_dec('h6B, 1, 2, 0, 6), "after_reload_char");

        // Reset mid-stream
        in_valid = 1'b1; in_char = 8'h3F; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("pre_rst_out_valid", int'(out_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_err_count", int'(err_count), 0);
        check("mid_rst_err_key", int'(err_key), 1);
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Randomized streams with random valid keys; small counter exercises saturation
        cnt = 0;
        for (int ep = 0; ep < 3; ep++) begin
            n1 = $urandom_range(0, 26);
            do n3 = $urandom_range(0, 26); while (n3 == n1);
            out_ready = 1'b1;
            load_keys(1'($urandom), n1, 1'($urandom), n3);
            check("rand_err_key", int'(err_key), 0);
            run_random(200, q, cnt);
        end
        check("err_count_saturated", int'(err_count), (1 << CW) - 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
